// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared types, geometry constants and address helpers for the
//                direct-mapped write-through data cache.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int SETS    = 64;
    localparam int INDEX_W = 6;
    localparam int TAG_W   = 32 - INDEX_W - 2;
    localparam int WORD_W  = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MISS = 2'd1,
        WRITE     = 2'd2
    } state_t;

    // Line index: word address modulo the number of sets.
    function automatic logic [INDEX_W-1:0] get_index(input logic [31:0] addr);
        return addr[INDEX_W+1:2];
    endfunction

    // Tag: everything above the index bits.
    function automatic logic [TAG_W-1:0] get_tag(input logic [31:0] addr);
        return addr[31:INDEX_W+2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_array.sv
`default_nettype none
// ============================================================================
//  Module      : cache_array
//  Description : Valid/tag/data storage for the direct-mapped cache with a
//                combinational lookup port and a single write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_array
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index_i,
    input  logic [TAG_W-1:0]   rd_tag_i,
    output logic               hit_o,
    output logic [WORD_W-1:0]  rd_data_o,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [WORD_W-1:0]  wr_data_i
);

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [WORD_W-1:0] data_q [SETS];

    // Valid bits: cleared on reset, set by any write (fill or store-hit).
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag and data payload; not reset, qualified by the valid bit.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end

    assign hit_o     = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);
    assign rd_data_o = data_q[rd_index_i];

endmodule
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cache_controller
//  Description : MEM-stage responder. Serves load hits from a direct-mapped
//                write-through, no-write-allocate cache in zero stall cycles;
//                forwards misses and all stores to SRAM via a ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_controller
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_en,
    input  logic        MEM_W_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_r_en,
    output logic        sram_w_en,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready
);

    state_t              state_q;
    state_t              state_d;
    logic                hit;
    logic [WORD_W-1:0]   arr_rdata;
    logic                arr_we;
    logic [WORD_W-1:0]   arr_wdata;
    logic [INDEX_W-1:0]  index;
    logic [TAG_W-1:0]    tag;
    logic                unused_lsb;

    assign index      = get_index(address);
    assign tag        = get_tag(address);
    assign unused_lsb = ^address[1:0];

    // SRAM side always sees the word-aligned request; strobes qualify it.
    assign sram_address = {address[31:2], 2'b00};
    assign sram_wdata   = wdata;

    cache_array u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_index_i (index),
        .rd_tag_i   (tag),
        .hit_o      (hit),
        .rd_data_o  (arr_rdata),
        .wr_en_i    (arr_we),
        .wr_index_i (index),
        .wr_tag_i   (tag),
        .wr_data_i  (arr_wdata)
    );

    // State register; reset aborts any outstanding SRAM access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake strobes, ready/rdata and cache write port.
    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        rdata     = '0;
        sram_r_en = 1'b0;
        sram_w_en = 1'b0;
        arr_we    = 1'b0;
        arr_wdata = wdata;
        case (state_q)
            IDLE: begin
                if (MEM_W_en) begin
                    // Store (also the illegal R+W case): write through, update on hit only.
                    sram_w_en = 1'b1;
                    arr_we    = hit;
                    state_d   = WRITE;
                end else if (MEM_R_en) begin
                    if (hit) begin
                        ready = 1'b1;
                        rdata = arr_rdata;
                    end else begin
                        sram_r_en = 1'b1;
                        state_d   = READ_MISS;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            READ_MISS: begin
                sram_r_en = 1'b1;
                if (sram_ready) begin
                    // Pass fill data straight through and allocate the line.
                    ready     = 1'b1;
                    rdata     = sram_rdata;
                    arr_we    = 1'b1;
                    arr_wdata = sram_rdata;
                    state_d   = IDLE;
                end
            end
            WRITE: begin
                sram_w_en = 1'b1;
                if (sram_ready) begin
                    ready   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_controller
//  Description : Self-checking bench for cache_controller: directed vector
//                table, reset/spurious-ready sequences and randomized traffic
//                against a behavioural cache + memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_en;
    logic        MEM_W_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_r_en;
    logic        sram_w_en;
    logic [31:0] sram_rdata = '0;
    logic        sram_ready;

    logic model_rdy = 1'b0;
    logic spurious  = 1'b0;
    int   lat       = 3;
    int   cnt       = 0;
    int   n_writes  = 0;
    int   n_reads   = 0;
    logic [31:0] last_w_addr = '0;
    logic [31:0] last_w_data = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] sram_mem [int unsigned];
    logic [31:0] ref_mem  [int unsigned];
    bit          rv  [64];
    logic [23:0] rt  [64];
    logic [31:0] rdd [64];

    always #5 clk = ~clk;

    assign sram_ready = model_rdy | spurious;

    cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .MEM_R_en     (MEM_R_en),
        .MEM_W_en     (MEM_W_en),
        .address      (address),
        .wdata        (wdata),
        .rdata        (rdata),
        .ready        (ready),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_r_en    (sram_r_en),
        .sram_w_en    (sram_w_en),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
    );

    function automatic logic [31:0] pattern(input int unsigned wa);
        return (wa * 32'h9E3779B1) ^ 32'hC3C3_0F0F;
    endfunction

    function automatic logic [31:0] sram_rd(input int unsigned wa);
        return sram_mem.exists(wa) ? sram_mem[wa] : pattern(wa);
    endfunction

    function automatic logic [31:0] ref_rd(input int unsigned wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : pattern(wa);
    endfunction

    // SRAM model: sram_ready pulses 'lat' cycles after a strobe first appears.
    always @(negedge clk) begin
        if (rst || !(sram_r_en || sram_w_en)) begin
            cnt       = 0;
            model_rdy = 1'b0;
        end else if (model_rdy) begin
            model_rdy = 1'b0;
            cnt       = 1;
        end else begin
            model_rdy = (cnt == lat);
            cnt++;
        end
        if (model_rdy) begin
            if (sram_w_en) begin
                sram_mem[sram_address >> 2] = sram_wdata;
                last_w_addr = sram_address;
                last_w_data = sram_wdata;
                n_writes++;
            end else begin
                sram_rdata = sram_rd(sram_address >> 2);
                n_reads++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural reference: cache lines plus backing memory, plain arithmetic.
    task automatic ref_apply(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                             output int exp_stall, output logic [31:0] exp_rd);
        int unsigned wa  = a / 4;
        int          idx = int'(wa % 64);
        logic [23:0] tg  = 24'(a >> 8);
        exp_rd    = '0;
        exp_stall = 0;
        if (w) begin
            ref_mem[wa] = d;
            if (rv[idx] && rt[idx] == tg) rdd[idx] = d;
            exp_stall = lat;
        end else if (r) begin
            if (rv[idx] && rt[idx] == tg) begin
                exp_rd = rdd[idx];
            end else begin
                exp_stall = lat;
                exp_rd    = ref_rd(wa);
                rv[idx]   = 1'b1;
                rt[idx]   = tg;
                rdd[idx]  = exp_rd;
            end
        end
    endtask

    // Present one request at the next cycle and wait (bounded) for ready.
    task automatic do_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int stall, output logic [31:0] rdv, output logic [31:0] saddr0,
                          output logic ren0, output logic wen0);
        @(posedge clk); #1;
        MEM_R_en = r;
        MEM_W_en = w;
        address  = a;
        wdata    = d;
        stall    = 0;
        @(negedge clk); #1;
        saddr0 = sram_address;
        ren0   = sram_r_en;
        wen0   = sram_w_en;
        while (!ready && stall <= 40) begin
            stall++;
            @(negedge clk); #1;
        end
        rdv = rdata;
    endtask

    task automatic run(input string nm, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input int exp_stall, input logic [31:0] exp_rd);
        int          stall;
        logic [31:0] rdv;
        logic [31:0] saddr0;
        logic        ren0;
        logic        wen0;
        int          wr_before = n_writes;
        do_req(r, w, a, d, stall, rdv, saddr0, ren0, wen0);
        chk({nm, "/stall"}, 32'(stall), 32'(exp_stall));
        chk({nm, "/r_en"}, 32'(ren0), 32'(r && !w && exp_stall > 0));
        chk({nm, "/w_en"}, 32'(wen0), 32'(w));
        if (exp_stall > 0) chk({nm, "/sram_addr"}, saddr0, {a[31:2], 2'b00});
        if (r && !w) chk({nm, "/rdata"}, rdv, exp_rd);
        if (w) begin
            chk({nm, "/sram_writes"}, 32'(n_writes - wr_before), 32'd1);
            chk({nm, "/w_addr"}, last_w_addr, {a[31:2], 2'b00});
            chk({nm, "/w_data"}, last_w_data, d);
        end
    endtask

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        int          stall;
        logic [31:0] rd;
    } vec_t;

    initial begin
        vec_t        vt [10];
        int          es;
        logic [31:0] er;

        vt[0] = '{1'b1, 1'b0, 32'h40,  32'h0,        3, 32'hDEADBEEF};
        vt[1] = '{1'b1, 1'b0, 32'h40,  32'h0,        0, 32'hDEADBEEF};
        vt[2] = '{1'b0, 1'b1, 32'h40,  32'h12345678, 3, 32'h0};
        vt[3] = '{1'b1, 1'b0, 32'h40,  32'h0,        0, 32'h12345678};
        vt[4] = '{1'b0, 1'b1, 32'h80,  32'hAAAA5555, 3, 32'h0};
        vt[5] = '{1'b1, 1'b0, 32'h80,  32'h0,        3, 32'hAAAA5555};
        vt[6] = '{1'b1, 1'b0, 32'h143, 32'h0,        3, 32'h0BADF00D};
        vt[7] = '{1'b1, 1'b0, 32'h40,  32'h0,        3, 32'h12345678};
        vt[8] = '{1'b1, 1'b1, 32'h40,  32'h55AA55AA, 3, 32'h0};
        vt[9] = '{1'b1, 1'b0, 32'h40,  32'h0,        0, 32'h55AA55AA};

        sram_mem[32'h10] = 32'hDEADBEEF;
        sram_mem[32'h50] = 32'h0BADF00D;
        ref_mem[32'h10]  = 32'hDEADBEEF;
        ref_mem[32'h50]  = 32'h0BADF00D;
        for (int i = 0; i < 64; i++) rv[i] = 1'b0;

        rst = 1'b1; MEM_R_en = 1'b0; MEM_W_en = 1'b0; address = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("reset/rdata_in_rst", rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("reset/ready", 32'(ready), 32'd1);
        chk("reset/r_en", 32'(sram_r_en), 32'd0);
        chk("reset/w_en", 32'(sram_w_en), 32'd0);
        chk("reset/rdata", rdata, 32'h0);

        // Directed vectors, back to back.
        lat = 3;
        for (int i = 0; i < 10; i++) begin
            ref_apply(vt[i].r, vt[i].w, vt[i].a, vt[i].d, es, er);
            run($sformatf("vec%0d", i), vt[i].r, vt[i].w, vt[i].a, vt[i].d, vt[i].stall, vt[i].rd);
        end

        // Reset in the middle of a read miss.
        @(posedge clk); #1;
        MEM_R_en = 1'b1; MEM_W_en = 1'b0; address = 32'hC0;
        @(negedge clk); #1;
        chk("rstmid/strobe", 32'(sram_r_en), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; MEM_R_en = 1'b0;
        @(negedge clk); #1;
        chk("rstmid/held", 32'(sram_r_en), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("rstmid/r_en_dropped", 32'(sram_r_en), 32'd0);
        chk("rstmid/idle_ready", 32'(ready), 32'd1);
        for (int i = 0; i < 64; i++) rv[i] = 1'b0;
        ref_apply(1'b1, 1'b0, 32'h40, 32'h0, es, er);
        run("rstmid/reload", 1'b1, 1'b0, 32'h40, 32'h0, 3, 32'h55AA55AA);

        // sram_ready while idle must be ignored.
        @(posedge clk); #1;
        MEM_R_en = 1'b0; MEM_W_en = 1'b0; spurious = 1'b1;
        @(negedge clk); #1;
        chk("spur/ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
        spurious = 1'b0;
        @(negedge clk); #1;
        chk("spur/ready_after", 32'(ready), 32'd1);
        chk("spur/no_strobe", 32'({sram_r_en, sram_w_en}), 32'd0);
        ref_apply(1'b1, 1'b0, 32'h40, 32'h0, es, er);
        run("spur/hit", 1'b1, 1'b0, 32'h40, 32'h0, 0, 32'h55AA55AA);

        // Randomized traffic on a small address pool to mix hits, conflicts and stores.
        for (int n = 0; n < 300; n++) begin
            int          k = int'($urandom_range(0, 9));
            logic        r = (k <= 5) || (k == 9);
            logic        w = (k >= 6);
            logic [31:0] a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            logic [31:0] d = $urandom;
            lat = int'($urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                MEM_R_en = 1'b0; MEM_W_en = 1'b0;
            end
            ref_apply(r, w, a, d, es, er);
            run($sformatf("rnd%0d", n), r, w, a, d, es, er);
        end

        @(posedge clk); #1;
        MEM_R_en = 1'b0; MEM_W_en = 1'b0;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Responder side of the MEM-stage memory interface.
- Accepts load/store requests from the MEM stage and serves loads from a direct-mapped, write-through, no-write-allocate data cache.
- Forwards misses and all stores to the SRAM controller through a ready handshake.
- Drives `ready`; the top level derives `cache_freeze = ~ready`, which stalls the pipeline stage registers, including MEM_Stage_Reg.

Parameters:
- SETS, 64, number of cache lines, one 32-bit word per line.
- INDEX_W, 6, log2(SETS); index = address[INDEX_W+1:2].
- TAG_W, 24, address[31:INDEX_W+2]; must equal 30-INDEX_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- MEM_R_en  in  1  load request from MEM stage.
- MEM_W_en  in  1  store request from MEM stage.
- address  in  32  byte address, already rebased to data memory; bits [1:0] ignored.
- wdata  in  32  store data.
- rdata  out  32  load data; valid only when ready=1 and MEM_R_en=1.
- ready  out  1  request complete this cycle; 1 when idle with no request.
- sram_address  out  32  word-aligned address to the SRAM controller.
- sram_wdata  out  32  store data to SRAM.
- sram_r_en  out  1  SRAM read strobe, held until sram_ready.
- sram_w_en  out  1  SRAM write strobe, held until sram_ready.
- sram_rdata  in  32  SRAM read data, valid with sram_ready.
- sram_ready  in  1  SRAM access done; single-cycle pulse.

Behaviour:
- Reset is synchronous: state=IDLE, all valid bits=0, sram_r_en=sram_w_en=0, rdata=0. Tag/data arrays are not reset.
- Reset mid-operation aborts the access. Strobes drop on the next cycle and the line is not filled.
- Requester contract: address, wdata, MEM_R_en and MEM_W_en stay stable while ready=0.
- Both MEM_R_en and MEM_W_en high at once is illegal; the block treats it as a store.
- FSM states: IDLE, READ_MISS, WRITE.
- IDLE, no request: ready=1.
- IDLE, load hit (valid[index] and tag match): ready=1 and rdata=data[index] combinationally in the same cycle. Zero stall cycles.
- IDLE, load miss: ready=0, sram_r_en=1, sram_address={address[31:2],2'b00}. Next state READ_MISS.
- IDLE, store: ready=0, sram_w_en=1, sram_wdata=wdata.
  - On a hit, data[index] is updated at the next clock edge.
  - On a miss, the cache is untouched (no allocate).
  - Next state WRITE.
- READ_MISS: hold sram_r_en. On the sram_ready cycle:
  - ready=1 and rdata=sram_rdata, passed through combinationally.
  - At the clock edge: data[index]=sram_rdata, tag[index]=tag, valid[index]=1.
  - Next state IDLE.
- WRITE: hold sram_w_en. On the sram_ready cycle, ready=1; next state IDLE.
- Strobes are deasserted in the cycle after sram_ready.
- Load latency:
  - Hit: 0 stall cycles.
  - Miss: N+1 cycles total, where N is the number of cycles from strobe to sram_ready.
- Store latency: the same as a load miss.
- Back-to-back requests: the requester advances on ready=1. A new request can be presented in the following cycle while the FSM is in IDLE; no bubble.
- A load that hits a line written in the previous cycle returns the new data.
- A load to the same index but a different tag is a miss and replaces the line.
- An sram_ready seen in IDLE is ignored.

Decomposition:
- Shared package cache_pkg:
  - state enum {IDLE, READ_MISS, WRITE}.
  - Constants SETS, INDEX_W, TAG_W, WORD_W=32.
  - Functions get_index(address) and get_tag(address).
- Sub-module cache_array:
  - valid/tag/data storage with synchronous clear of the valid bits on rst.
  - Combinational read port giving hit and data.
  - One write port (fill or store-hit update).
- cache_controller holds the FSM and SRAM handshake, and instantiates cache_array.

Test Plan:
- Reset, then a load at 0x40: miss; sram_r_en=1 with sram_address=0x40. The SRAM model returns 0xDEADBEEF after 3 cycles. ready=0 for 3 cycles, then ready=1 with rdata=0xDEADBEEF.
- Repeat the load at 0x40: ready=1 in the same cycle, rdata=0xDEADBEEF, sram_r_en stays 0.
- Store 0x12345678 to 0x40 (hit): sram_w_en held until sram_ready. Then a load at 0x40 hits and returns 0x12345678 with no SRAM read.
- Store to 0x80 (miss, uncached): the SRAM write occurs. A following load at 0x80 misses, which proves no allocate.
- Load 0x140 (same index as 0x40, different tag): miss and fill. A load at 0x40 then misses again.
- Assert rst during READ_MISS: the next cycle has sram_r_en=0 and state IDLE. A load at 0x40 misses because valid was cleared.
